// File: rtl/fib_inst_issuer.sv
// Fibonacci program source for the single-cycle CPU: two addi seeds, N alternating
// adds, then a one-cycle done pulse. All outputs are registered.
module fib_inst_issuer #(
   parameter int N     = 10,
   parameter int REG_A = 1,
   parameter int REG_B = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stall,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic        busy,
   output logic        done,
   output logic [7:0]  count
);

   typedef enum logic [2:0] {IDLE, INIT_A, INIT_B, LOOP, DONE} state_t;

   localparam logic [4:0]  RA     = 5'(REG_A);
   localparam logic [4:0]  RB     = 5'(REG_B);
   localparam logic [7:0]  LAST   = 8'((N == 0) ? 0 : N - 1);
   localparam logic [31:0] ADDI_A = {6'b001000, 5'd0, RA, 16'h0001};
   localparam logic [31:0] ADDI_B = {6'b001000, 5'd0, RB, 16'h0001};
   localparam logic [31:0] NOP    = 32'h0000_0000;

   // Even-numbered adds write REG_A, odd-numbered adds write REG_B.
   function automatic logic [31:0] add_word(input logic odd);
      return {6'b000000, RA, RB, (odd ? RB : RA), 5'b00000, 6'b100000};
   endfunction

   state_t      state_q, state_d;
   logic [31:0] inst_q, inst_d;
   logic        inst_valid_q, inst_valid_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [7:0]  count_q, count_d;
   logic        accept;

   assign accept = inst_valid_q && !stall;

   always_comb begin
      state_d      = state_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      count_d      = count_q;
      case (state_q)
         IDLE: begin
            inst_d       = NOP;
            inst_valid_d = 1'b0;
            busy_d       = 1'b0;
            if (start) begin
               state_d      = INIT_A;
               count_d      = 8'd0;
               inst_d       = ADDI_A;
               inst_valid_d = 1'b1;
               busy_d       = 1'b1;
            end
         end
         INIT_A: begin
            if (accept) begin
               state_d = INIT_B;
               inst_d  = ADDI_B;
            end
         end
         INIT_B: begin
            if (accept) begin
               if (N == 0) begin
                  state_d      = DONE;
                  inst_d       = NOP;
                  inst_valid_d = 1'b0;
                  busy_d       = 1'b0;
                  done_d       = 1'b1;
               end else begin
                  state_d = LOOP;
                  inst_d  = add_word(1'b0);
               end
            end
         end
         LOOP: begin
            // count doubles as the index k of the add currently on inst.
            if (accept) begin
               count_d = count_q + 8'd1;
               if (count_q == LAST) begin
                  state_d      = DONE;
                  inst_d       = NOP;
                  inst_valid_d = 1'b0;
                  busy_d       = 1'b0;
                  done_d       = 1'b1;
               end else begin
                  inst_d = add_word(count_d[0]);
               end
            end
         end
         DONE: begin
            state_d      = IDLE;
            inst_d       = NOP;
            inst_valid_d = 1'b0;
            busy_d       = 1'b0;
         end
         default: begin
            state_d      = IDLE;
            inst_d       = NOP;
            inst_valid_d = 1'b0;
            busy_d       = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         inst_q       <= NOP;
         inst_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         count_q      <= 8'd0;
      end else begin
         state_q      <= state_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         count_q      <= count_d;
      end
   end

   assign inst       = inst_q;
   assign inst_valid = inst_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign count      = count_q;

endmodule

// File: tb/tb_fib_inst_issuer.sv
// Bench for fib_inst_issuer: per-cycle vector table on a default instance with an
// accepted-instruction scoreboard, plus short sequences for N=0 and remapped registers.
module tb_fib_inst_issuer;

   localparam logic [31:0] ADDI_A = 32'h2001_0001;
   localparam logic [31:0] ADDI_B = 32'h2002_0001;
   localparam logic [31:0] EVEN   = 32'h0022_0820;
   localparam logic [31:0] ODD    = 32'h0022_1020;

   typedef struct {
      logic        rst_n;
      logic        start;
      logic        stall;
      logic        prog;
      logic [31:0] inst;
      logic        valid;
      logic        busy;
      logic        done;
      logic [7:0]  count;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start0 = 1'b0, stall0 = 1'b0;
   logic        start1 = 1'b0, start2 = 1'b0;
   logic        stall_x = 1'b0;
   logic [31:0] inst0, inst1, inst2;
   logic        valid0, valid1, valid2;
   logic        busy0, busy1, busy2;
   logic        done0, done1, done2;
   logic [7:0]  count0, count1, count2;

   int errors = 0;
   int checks = 0;
   vec_t tbl[$];
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   fib_inst_issuer u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .stall(stall0),
      .inst(inst0), .inst_valid(valid0), .busy(busy0), .done(done0), .count(count0));

   fib_inst_issuer #(.N(0)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .stall(stall_x),
      .inst(inst1), .inst_valid(valid1), .busy(busy1), .done(done1), .count(count1));

   fib_inst_issuer #(.N(2), .REG_A(3), .REG_B(4)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .stall(stall_x),
      .inst(inst2), .inst_valid(valid2), .busy(busy2), .done(done2), .count(count2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic s, input logic st, input logic p,
                      input logic [31:0] i, input logic v, input logic b,
                      input logic d, input logic [7:0] c);
      vec_t e;
      e.rst_n = r; e.start = s; e.stall = st; e.prog = p;
      e.inst = i; e.valid = v; e.busy = b; e.done = d; e.count = c;
      tbl.push_back(e);
   endtask

   task automatic push_prog();
      sb.push_back(ADDI_A);
      sb.push_back(ADDI_B);
      for (int k = 0; k < 10; k++) sb.push_back(k[0] ? ODD : EVEN);
   endtask

   // Every instruction the default instance hands over must be the next one expected.
   always @(negedge clk) begin
      if (rst_n && valid0 && !stall0) begin
         if (sb.size() == 0) chk("sb_unexpected", inst0, 32'hxxxx_xxxx);
         else chk("sb_inst", inst0, sb.pop_front());
      end
   end

   task automatic chk_out(input string nm, input logic [31:0] ai, input logic av,
                          input logic ab, input logic ad, input logic [7:0] ac,
                          input logic [31:0] ei, input logic ev, input logic eb,
                          input logic ed, input logic [7:0] ec);
      chk({nm, ".inst"}, ai, ei);
      chk({nm, ".valid"}, {31'd0, av}, {31'd0, ev});
      chk({nm, ".busy"}, {31'd0, ab}, {31'd0, eb});
      chk({nm, ".done"}, {31'd0, ad}, {31'd0, ed});
      chk({nm, ".count"}, {24'd0, ac}, {24'd0, ec});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset, reset beating start, stall ignored in idle
      add(0,0,0,0, 32'h0,0,0,0,0);
      add(0,1,0,0, 32'h0,0,0,0,0);
      add(1,0,1,0, 32'h0,0,0,0,0);
      // plain run
      add(1,1,0,1, ADDI_A,1,1,0,0);
      add(1,0,0,0, ADDI_B,1,1,0,0);
      for (int k = 0; k < 10; k++) add(1,0,0,0, k[0] ? ODD : EVEN,1,1,0,8'(k));
      add(1,0,0,0, 32'h0,0,0,1,10);
      add(1,0,0,0, 32'h0,0,0,0,10);
      // restart with stall at k=1, start during LOOP and DONE ignored
      add(1,1,0,1, ADDI_A,1,1,0,0);
      add(1,0,0,0, ADDI_B,1,1,0,0);
      add(1,0,0,0, EVEN,1,1,0,0);
      add(1,0,0,0, ODD,1,1,0,1);
      for (int j = 0; j < 3; j++) add(1,0,1,0, ODD,1,1,0,1);
      for (int k = 2; k < 10; k++) add(1, k == 5, 0,0, k[0] ? ODD : EVEN,1,1,0,8'(k));
      add(1,0,0,0, 32'h0,0,0,1,10);
      add(1,1,0,0, 32'h0,0,0,0,10);
      add(1,0,1,0, 32'h0,0,0,0,10);
      // reset in the middle of LOOP at k=4
      add(1,1,0,1, ADDI_A,1,1,0,0);
      add(1,0,0,0, ADDI_B,1,1,0,0);
      for (int k = 0; k < 5; k++) add(1,0,0,0, k[0] ? ODD : EVEN,1,1,0,8'(k));
      add(0,0,0,0, 32'h0,0,0,0,0);
      add(1,0,0,0, 32'h0,0,0,0,0);
      add(1,0,0,0, 32'h0,0,0,0,0);

      step();
      for (int i = 0; i < tbl.size(); i++) begin
         rst_n  = tbl[i].rst_n;
         start0 = tbl[i].start;
         stall0 = tbl[i].stall;
         if (!tbl[i].rst_n) sb.delete();
         if (tbl[i].prog) push_prog();
         step();
         chk_out($sformatf("row%0d", i), inst0, valid0, busy0, done0, count0,
                 tbl[i].inst, tbl[i].valid, tbl[i].busy, tbl[i].done, tbl[i].count);
      end
      start0 = 1'b0;
      stall0 = 1'b0;
      chk("sb_left", sb.size(), 32'd0);

      // N=0: two seeds then done, never an add
      start1 = 1'b1; step(); start1 = 1'b0;
      chk_out("n0.a", inst1, valid1, busy1, done1, count1, ADDI_A,1,1,0,0);
      step();
      chk_out("n0.b", inst1, valid1, busy1, done1, count1, ADDI_B,1,1,0,0);
      step();
      chk_out("n0.done", inst1, valid1, busy1, done1, count1, 32'h0,0,0,1,0);
      step();
      chk_out("n0.idle", inst1, valid1, busy1, done1, count1, 32'h0,0,0,0,0);

      // REG_A=3, REG_B=4, N=2
      start2 = 1'b1; step(); start2 = 1'b0;
      chk_out("r34.a", inst2, valid2, busy2, done2, count2, 32'h2003_0001,1,1,0,0);
      step();
      chk_out("r34.b", inst2, valid2, busy2, done2, count2, 32'h2004_0001,1,1,0,0);
      step();
      chk_out("r34.k0", inst2, valid2, busy2, done2, count2, 32'h0064_1820,1,1,0,0);
      step();
      chk_out("r34.k1", inst2, valid2, busy2, done2, count2, 32'h0064_2020,1,1,0,1);
      step();
      chk_out("r34.done", inst2, valid2, busy2, done2, count2, 32'h0,0,0,1,2);
      step();
      chk_out("r34.idle", inst2, valid2, busy2, done2, count2, 32'h0,0,0,0,2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
